// File: rtl/aes_encipher_ctrl_if.sv
// aes_encipher_ctrl_if
//   Bundles the control handshake and the datapath/state buses of the AES
//   encipher sequencer.
//   master : core FSM + round datapath side (drives next/keylen/block/state_new)
//   slave  : the sequencer itself
//   Signals:
//     next, keylen, block        start request, key length, plaintext
//     ready, result, result_valid idle flag, ciphertext, ciphertext valid
//     round, round_type          round-key index and datapath mode
//     sbox_mux_ctrl              row presented to the shared S-boxes
//     state, state_new           state to the datapath, datapath result
interface aes_encipher_ctrl_if;
  logic         next;
  logic         keylen;
  logic [127:0] block;
  logic         ready;
  logic [127:0] result;
  logic         result_valid;
  logic [3:0]   round;
  logic [1:0]   round_type;
  logic [1:0]   sbox_mux_ctrl;
  logic [127:0] state;
  logic [127:0] state_new;

  modport master (
    output next, keylen, block, state_new,
    input  ready, result, result_valid, round, round_type, sbox_mux_ctrl, state
  );

  modport slave (
    input  next, keylen, block, state_new,
    output ready, result, result_valid, round, round_type, sbox_mux_ctrl, state
  );
endinterface

// File: rtl/aes_encipher_ctrl.sv
// aes_encipher_ctrl
//   Sequencer for the shared AES encipher round datapath. Holds the 128-bit
//   cipher state, steps the datapath through INIT, four shared-S-box SUB
//   passes per round, and a MIX (main/final) round, then presents the
//   ciphertext with a valid flag.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      aes_encipher_ctrl_if.slave (handshake, state and control buses)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready, waiting for next; result/result_valid held
//   INIT  | initial AddRoundKey with key 0, full 128-bit capture
//   SUB   | 4 cycles, one state row substituted per cycle
//   MIX   | main (r<N) or final (r==N) round, full 128-bit capture
module aes_encipher_ctrl #(
  parameter int unsigned AES128_ROUNDS = 10,
  parameter int unsigned AES256_ROUNDS = 14
) (
  input logic               clk,
  input logic               reset_n,
  aes_encipher_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_SUB  = 2'd2,
    ST_MIX  = 2'd3
  } fsm_e;

  localparam logic [1:0] RT_INIT  = 2'd0;
  localparam logic [1:0] RT_MAIN  = 2'd1;
  localparam logic [1:0] RT_FINAL = 2'd2;
  localparam logic [1:0] RT_SUB   = 2'd3;

  localparam logic [3:0] NR128 = 4'(AES128_ROUNDS);
  localparam logic [3:0] NR256 = 4'(AES256_ROUNDS);

  fsm_e         r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_round;
  logic [3:0]   r_nr;
  logic [1:0]   r_round_type;
  logic [1:0]   r_row;
  logic         r_ready;
  logic         r_valid;

  logic [127:0] w_sub_state;
  logic         w_last_round;

  // Row r of the column-major state is byte index 4c+r, so selecting the
  // bytes whose index mod 4 equals the row replaces exactly s_r0..s_r3.
  always_comb begin
    w_sub_state = r_state;
    for (int i = 0; i < 16; i++) begin
      if (2'(i) == r_row) begin
        w_sub_state[127-8*i -: 8] = bus.state_new[127-8*i -: 8];
      end
    end
  end

  assign w_last_round = (r_round == r_nr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm        <= ST_IDLE;
      r_state      <= '0;
      r_round      <= '0;
      r_nr         <= NR128;
      r_round_type <= RT_INIT;
      r_row        <= '0;
      r_ready      <= 1'b1;
      r_valid      <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (bus.next) begin
            r_state <= bus.block;
            r_nr    <= bus.keylen ? NR256 : NR128;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
            r_fsm   <= ST_INIT;
          end
        end
        ST_INIT: begin
          r_state      <= bus.state_new;
          r_round      <= 4'd1;
          r_round_type <= RT_SUB;
          r_row        <= 2'd0;
          r_fsm        <= ST_SUB;
        end
        ST_SUB: begin
          r_state <= w_sub_state;
          if (r_row == 2'd3) begin
            r_row        <= 2'd0;
            r_round_type <= w_last_round ? RT_FINAL : RT_MAIN;
            r_fsm        <= ST_MIX;
          end else begin
            r_row <= r_row + 2'd1;
          end
        end
        ST_MIX: begin
          r_state <= bus.state_new;
          if (w_last_round) begin
            r_round      <= 4'd0;
            r_round_type <= RT_INIT;
            r_valid      <= 1'b1;
            r_ready      <= 1'b1;
            r_fsm        <= ST_IDLE;
          end else begin
            r_round      <= r_round + 4'd1;
            r_round_type <= RT_SUB;
            r_fsm        <= ST_SUB;
          end
        end
        default: begin
          r_fsm <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready         = r_ready;
  assign bus.result        = r_state;
  assign bus.result_valid  = r_valid;
  assign bus.round         = r_round;
  assign bus.round_type    = r_round_type;
  assign bus.sbox_mux_ctrl = r_row;
  assign bus.state         = r_state;

endmodule

// File: tb/tb_aes_encipher_ctrl.sv
module tb_aes_encipher_ctrl;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk;
  logic         reset_n;
  logic [127:0] rk [0:14];
  logic [127:0] w_rk;
  int           n_cmp;
  int           n_bad;

  aes_encipher_ctrl_if bus();

  aes_encipher_ctrl #(.AES128_ROUNDS(10), .AES256_ROUNDS(14)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference round datapath and key schedule ----------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] p, b, e;
    p = 8'h01; b = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) p = gm(p, b);
      b = gm(b, b);
    end
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] getb(input logic [127:0] s, input int r, input int c);
    return s[127-8*(4*c+r) -: 8];
  endfunction

  function automatic logic [127:0] putb(input logic [127:0] s, input int r, input int c,
                                        input logic [7:0] v);
    logic [127:0] o;
    o = s;
    o[127-8*(4*c+r) -: 8] = v;
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o = putb(o, r, c, getb(s, r, (c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = s;
    for (int c = 0; c < 4; c++) begin
      a0 = getb(s, 0, c); a1 = getb(s, 1, c); a2 = getb(s, 2, c); a3 = getb(s, 3, c);
      o = putb(o, 0, c, xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3);
      o = putb(o, 1, c, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3);
      o = putb(o, 2, c, a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3);
      o = putb(o, 3, c, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3));
    end
    return o;
  endfunction

  // The stub substitutes every byte; only the selected row may be kept.
  function automatic logic [127:0] sub_all(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sb(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] row_merge(input logic [127:0] old_s, input logic [127:0] new_s,
                                             input int row);
    logic [127:0] o;
    o = old_s;
    for (int c = 0; c < 4; c++) o = putb(o, row, c, getb(new_s, row, c));
    return o;
  endfunction

  function automatic logic [127:0] dp_model(input logic [127:0] s, input logic [1:0] rt,
                                            input logic [127:0] k);
    case (rt)
      2'd0:    return s ^ k;
      2'd1:    return mix_cols(shift_rows(s)) ^ k;
      2'd2:    return shift_rows(s) ^ k;
      default: return sub_all(s);
    endcase
  endfunction

  always_comb w_rk = rk[bus.round];
  always_comb bus.state_new = dp_model(bus.state, bus.round_type, w_rk);

  task automatic expand_key(input logic [255:0] key, input bit k256);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = k256 ? 8 : 4;
    nr = k256 ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]) ^ rc, sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // ---------------- checking helpers -----------------------------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {round, round_type, sbox_mux_ctrl} in the cycle after edge E_k.
  function automatic logic [7:0] exp_ctl(input int k, input int n);
    int r, p;
    if (k == 0) return 8'h00;
    r = (k - 1) / 5 + 1;
    p = (k - 1) % 5;
    if (p < 4) return {4'(r), 2'd3, 2'(p)};
    return {4'(r), (r == n) ? 2'd2 : 2'd1, 2'd0};
  endfunction

  task automatic run_block(input string tag, input logic [127:0] blk, input bit k256,
                           input logic [127:0] exp_ct, input bit poke);
    int n, k, row;
    bit in_sub;
    logic [127:0] pre, snap;
    n = k256 ? 14 : 10;
    expand_key(k256 ? KEY256 : KEY128, k256);
    check({tag, ".ready_pre"}, bus.ready, 1);
    bus.block  = blk;
    bus.keylen = k256;
    bus.next   = 1'b1;
    tick();
    bus.next   = 1'b0;
    bus.block  = ~blk;
    bus.keylen = ~k256;
    check({tag, ".ready_busy"}, bus.ready, 0);
    check({tag, ".valid_drop"}, bus.result_valid, 0);
    for (k = 0; k < 200; k++) begin
      if (bus.result_valid) break;
      if (k <= 5*n) check({tag, ".ctl"}, {bus.round, bus.round_type, bus.sbox_mux_ctrl}, exp_ctl(k, n));
      in_sub = (k >= 1) && (k <= 5*n) && (((k - 1) % 5) < 4);
      row    = (k - 1) % 5;
      pre    = bus.state;
      snap   = bus.state_new;
      if (poke && (k == 5 || k == 30)) begin
        bus.next   = 1'b1;
        bus.block  = ~blk;
        bus.keylen = 1'b1;
      end
      tick();
      bus.next = 1'b0;
      if (in_sub) check({tag, ".sub_row"}, bus.state, row_merge(pre, snap, row));
    end
    check({tag, ".edges"}, 128'(k), 128'(5*n+1));
    check({tag, ".result"}, bus.result, exp_ct);
    check({tag, ".ready_done"}, bus.ready, 1);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, ".ready"}, bus.ready, 1);
    check({tag, ".valid"}, bus.result_valid, 0);
    check({tag, ".result"}, bus.result, 0);
    check({tag, ".state"}, bus.state, 0);
    check({tag, ".ctl"}, {bus.round, bus.round_type, bus.sbox_mux_ctrl}, 0);
  endtask

  // ---------------- directed sequence ----------------------------------
  initial begin
    int k;
    n_cmp      = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    bus.next   = 1'b0;
    bus.keylen = 1'b0;
    bus.block  = '0;
    for (int r = 0; r < 15; r++) rk[r] = '0;
    repeat (3) tick();
    check_idle_reset("reset");
    reset_n = 1'b1;
    tick();

    // FIPS-197 C.1 with full control trace and row-only SUB captures
    run_block("c1", PT, 1'b0, CT128, 1'b0);
    repeat (3) tick();
    check("idle_hold.result", bus.result, CT128);
    check("idle_hold.valid", bus.result_valid, 1);
    check("idle_hold.ctl", {bus.ready, bus.round, bus.round_type, bus.sbox_mux_ctrl}, 9'h100);

    // FIPS-197 C.3
    run_block("c3", PT, 1'b1, CT256, 1'b0);

    // next pulses while busy must be ignored
    run_block("busy", PT, 1'b0, CT128, 1'b1);

    // reset in the middle of a run
    expand_key(KEY128, 1'b0);
    bus.block  = PT;
    bus.keylen = 1'b0;
    bus.next   = 1'b1;
    tick();
    bus.next = 1'b0;
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    check_idle_reset("rst_mid");
    repeat (2) tick();
    check_idle_reset("rst_hold");
    reset_n = 1'b1;
    tick();
    run_block("rst_rerun", PT, 1'b0, CT128, 1'b0);

    // back-to-back with next held high
    expand_key(KEY128, 1'b0);
    bus.block  = PT;
    bus.keylen = 1'b0;
    bus.next   = 1'b1;
    tick();
    k = 0;
    while (!bus.result_valid && k < 200) begin
      tick();
      k++;
    end
    check("b2b.first_edges", 128'(k), 128'(51));
    check("b2b.first_result", bus.result, CT128);
    check("b2b.first_ready", bus.ready, 1);
    tick();
    check("b2b.valid_drop", bus.result_valid, 0);
    check("b2b.ready_drop", bus.ready, 0);
    bus.next = 1'b0;
    k = 0;
    while (!bus.result_valid && k < 200) begin
      tick();
      k++;
    end
    check("b2b.second_edges", 128'(k), 128'(51));
    check("b2b.second_result", bus.result, CT128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_encipher_ctrl.md
# aes_encipher_ctrl

Sequencer for the shared AES encipher round datapath. It holds the 128-bit cipher state register and accepts a plaintext block on a `next` pulse. It then steps the combinational round logic through the initial round, the 4-cycle shared-S-box substitution passes, and the main and final mix/key rounds. It drives the round index to the key memory and returns the ciphertext with a valid flag. It sits between the top-level core FSM, the round datapath and the round-key memory.

## Interface
- `AES128_ROUNDS`, 10, number of rounds when `keylen`=0.
- `AES256_ROUNDS`, 14, number of rounds when `keylen`=1.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `next` in 1: start request; accepted only when `ready`=1.
- `keylen` in 1: 0 = AES-128, 1 = AES-256; sampled on the accepting edge.
- `block` in 128: plaintext; sampled on the accepting edge.
- `ready` out 1: idle and able to accept `next`.
- `result` out 128: ciphertext; equals the state register.
- `result_valid` out 1: `result` holds a completed ciphertext.
- `round` out 4: round-key index to the key memory.
- `round_type` out 2: datapath mode. 0 = INIT, 1 = MAIN, 2 = FINAL, 3 = SUB (byte-substitution pass).
- `sbox_mux_ctrl` out 2: state row presented to the 4 shared S-boxes during SUB.
- `state` out 128: current state to the datapath.
- `state_new` in 128: datapath result for the current `round_type`.

State packing is column-major: byte s_rc occupies bits [127-8*(4c+r) -: 8]. Column 0 is [127:96], ordered s00, s10, s20, s30.

## Operation
- FSM states are IDLE, INIT, SUB, MIX.
- **IDLE.** Outputs are `ready`=1, `round`=0, `round_type`=0 and `sbox_mux_ctrl`=0. When `next`=1, the block does the following:
  - loads `block` into the state register;
  - latches `keylen` into an internal N (10 or 14);
  - clears `result_valid` and `ready`;
  - moves to INIT.
- **INIT** (1 cycle). `round`=0, `round_type`=INIT. Captures all 128 bits of `state_new`, sets the round counter r=1, and moves to SUB.
- **SUB** (4 cycles). `round`=r, `round_type`=SUB, `sbox_mux_ctrl` steps 0,1,2,3.
  - Each cycle captures only row `sbox_mux_ctrl` (bytes s_r0..s_r3) from `state_new`.
  - The other 96 bits are held.
  - After the cycle with `sbox_mux_ctrl`=3, moves to MIX.
- **MIX** (1 cycle). `round`=r, `round_type`=MAIN if r<N, FINAL if r==N. Captures all 128 bits.
  - If r<N: r increments and the FSM returns to SUB.
  - If r==N: sets `result_valid`=1 and `ready`=1, and returns to IDLE.
- The round counter is 4 bits and never wraps: its maximum is 14, and it is reset to 0 in IDLE.
- `sbox_mux_ctrl` is 0 outside SUB.
- `next` while `ready`=0 is ignored, with no effect on the sequence, `keylen` or state.
- Changes to `keylen` or `block` after acceptance have no effect.
- `result` and `result_valid` stay stable in IDLE until the next accepting edge. `result_valid` drops on that edge.
- Reset, including mid-operation, forces IDLE immediately:
  - state register = 0, `result` = 0;
  - `result_valid` = 0, `ready` = 1;
  - `round` = 0, `round_type` = 0, `sbox_mux_ctrl` = 0;
  - round counter = 0.

## Timing
- All outputs are driven from registers, or decoded from the FSM state and counters only. No combinational path runs from inputs to outputs.
- Call the accepting edge E0. Then:
  - INIT capture happens at E1.
  - Round r SUB captures happen at E(5r-3)..E(5r).
  - Round r MIX capture happens at E(5r+1).
- `ready` and `result_valid` rise after E(5N+1): 51 edges for AES-128, 71 edges for AES-256.
- `ready`=0 from after E0 through E(5N+1). Back-to-back throughput is one block per 5N+2 cycles when `next` is held high.
- `round` is valid for the whole cycle in which the datapath uses it. The key memory must be combinational-read, or must present key r in that same cycle.

## Test plan
- **FIPS-197 C.1.** Controller + round datapath + key model, `keylen`=0, key 000102…0f, block 00112233445566778899aabbccddeeff. Expect `result` = 69c4e0d86a7b0430d8cdb78070b4c55a, with `result_valid` rising exactly 51 edges after acceptance.
- **FIPS-197 C.3.** `keylen`=1, key 000102…1f, same block. Expect `result` = 8ea2b7ca516745bfeafc49904b496089 after 71 edges.
- **Sequence trace with a stub datapath.** Expect `round`/`round_type`/`sbox_mux_ctrl` to run 0/0/0, then 1/3/0..3, 1/1/0, …, 10/3/0..3, 10/2/0. Also check that SUB writes alter only the selected row.
- **Busy rejection.** Pulse `next` with a different block and with `keylen`=1 at cycles 5 and 30 of an AES-128 run. Expect the C.1 result unchanged, still at 51 edges.
- **Reset mid-operation.** Assert `reset_n`=0 at cycle 20. Expect immediate `ready`=1, `result_valid`=0, `result`=0, all control outputs 0. A fresh C.1 run after release passes.
- **Back-to-back.** Hold `next`=1 across two blocks. Expect `result_valid` to drop on the second accept, the second result to be correct, and 52-cycle spacing.
